// File: rtl/huffman_sequencer.sv
// Huffman scan sequencer: buffers scan words, drives the decoder and emits
// (idx, coef) beats. Optional macro HUFF_SEQ_DC_PRED_EN adds a DC predictor.
//
// Ports:
//   clk, reset (async, active-low), start, blk_count
//   in_valid/in_ready/in_data     : 32-bit scan words, first bit in bit 31
//   dec_code/dec_table_sel        : next 16 stream bits and DC/AC table select
//   dec_run/dec_vli_size/dec_code_size/dec_valid : decoder result
//   out_valid/out_ready/out_idx/out_coef/out_blk_end : coefficient beats
//   busy, done (one-cycle pulse), err
module huffman_sequencer #(
    parameter int BLOCKS_W = 16,
    parameter int COEF_W   = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [BLOCKS_W-1:0]        blk_count,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_data,
    output logic [15:0]                dec_code,
    output logic                       dec_table_sel,
    input  logic [3:0]                 dec_run,
    input  logic [3:0]                 dec_vli_size,
    input  logic [3:0]                 dec_code_size,
    input  logic                       dec_valid,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_idx,
    output logic signed [COEF_W-1:0]   out_coef,
    output logic                       out_blk_end,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DC   = 3'd1;
    localparam logic [2:0] S_AC   = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [63:0]                buf_q, buf_d;
    logic [6:0]                 cnt_q, cnt_d, cnt_sub;
    logic [5:0]                 idx_q, idx_d;
    logic [BLOCKS_W-1:0]        rem_q, rem_d;
    logic                       ov_q, oend_q, done_q, done_d;
    logic [5:0]                 oidx_q;
    logic signed [COEF_W-1:0]   ocoef_q;

    logic                       active, acc, fire, sym_bad;
    logic                       is_eob, is_zrl, ac_over, blk_end;
    logic [4:0]                 cons, used;
    logic [10:0]                vli_win, vli_raw;
    logic [11:0]                v12, vtop, vmask, coef12;
    logic [6:0]                 ac_step, ac_idx;
    logic signed [COEF_W-1:0]   diff, dc_val, e_coef;
    logic                       emit, e_end, dc_take;
    logic [5:0]                 e_idx;

    assign active        = (state_q == S_DC) || (state_q == S_AC);
    assign in_ready      = active && (cnt_q <= 7'd32);
    assign acc           = in_valid && in_ready;
    assign fire          = active && (cnt_q >= 7'd32) && (!ov_q || out_ready);
    assign dec_code      = buf_q[63:48];
    assign dec_table_sel = (state_q == S_AC);

    assign cons    = {1'b0, dec_code_size} + {1'b0, dec_vli_size};
    assign sym_bad = !dec_valid || (dec_code_size == 4'd0) ||
                     (dec_vli_size > 4'd11);

    // VLI bits follow the code and may extend past the 16-bit decoder window
    assign vli_win = 11'(buf_q >> (6'd53 - {2'b0, dec_code_size}));
    assign vli_raw = vli_win >> (4'd11 - dec_vli_size);
    assign v12     = {1'b0, vli_raw};
    assign vtop    = 12'd1 << (dec_vli_size - 4'd1);
    assign vmask   = (12'd1 << dec_vli_size) - 12'd1;
    assign coef12  = (dec_vli_size == 4'd0) ? 12'd0 :
                     ((v12 & vtop) != 12'd0) ? v12 : v12 - vmask;
    assign diff    = COEF_W'($signed(coef12));

    assign is_eob  = (dec_run == 4'd0) && (dec_vli_size == 4'd0);
    assign is_zrl  = (dec_run == 4'd15) && (dec_vli_size == 4'd0);
    assign ac_step = is_zrl ? 7'd16 : {3'b0, dec_run} + 7'd1;
    assign ac_idx  = {1'b0, idx_q} + ac_step;
    assign ac_over = !is_eob && (ac_idx > 7'd63);
    assign dc_take = fire && (state_q == S_DC) && !sym_bad;

`ifdef HUFF_SEQ_DC_PRED_EN
    logic signed [COEF_W-1:0] pred_q;

    assign dc_val = pred_q + diff;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pred_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            pred_q <= '0;
        end else if (dc_take) begin
            pred_q <= dc_val;
        end
    end
`else
    assign dc_val = diff;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        emit    = 1'b0;
        e_idx   = idx_q;
        e_coef  = '0;
        e_end   = 1'b0;
        used    = 5'd0;
        blk_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (blk_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_DC;
                        rem_d   = blk_count;
                    end
                end
            end
            S_DC, S_AC: begin
                if (fire) begin
                    if (sym_bad) begin
                        state_d = S_ERR;
                    end else if (state_q == S_DC) begin
                        used    = cons;
                        emit    = 1'b1;
                        e_idx   = 6'd0;
                        e_coef  = dc_val;
                        idx_d   = 6'd0;
                        state_d = S_AC;
                    end else if (ac_over) begin
                        state_d = S_ERR;
                    end else if (is_eob) begin
                        used    = cons;
                        emit    = 1'b1;
                        e_end   = 1'b1;
                        blk_end = 1'b1;
                    end else if (is_zrl) begin
                        used  = cons;
                        idx_d = ac_idx[5:0];
                    end else begin
                        used    = cons;
                        emit    = 1'b1;
                        e_idx   = ac_idx[5:0];
                        e_coef  = diff;
                        idx_d   = ac_idx[5:0];
                        e_end   = (ac_idx == 7'd63);
                        blk_end = (ac_idx == 7'd63);
                    end
                    // last block waits in FIN until its final beat drains
                    if (blk_end) begin
                        if (rem_q == BLOCKS_W'(1)) begin
                            state_d = S_FIN;
                        end else begin
                            state_d = S_DC;
                        end
                        rem_d = rem_q - BLOCKS_W'(1);
                    end
                end
            end
            S_FIN: begin
                if (ov_q && out_ready) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // new word lands directly below the bits left after this cycle's consume
    assign cnt_sub = cnt_q - {2'b0, used};

    always_comb begin
        buf_d = buf_q << used;
        cnt_d = cnt_sub;
        if (acc) begin
            buf_d = buf_d | ({in_data, 32'h0} >> cnt_sub);
            cnt_d = cnt_sub + 7'd32;
        end
        if (state_q == S_IDLE && start) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            ov_q    <= 1'b0;
            oidx_q  <= '0;
            ocoef_q <= '0;
            oend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            if (emit) begin
                ov_q    <= 1'b1;
                oidx_q  <= e_idx;
                ocoef_q <= e_coef;
                oend_q  <= e_end;
            end else if (out_ready) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign out_valid   = ov_q && (state_q != S_ERR);
    assign out_idx     = oidx_q;
    assign out_coef    = ocoef_q;
    assign out_blk_end = oend_q;
    assign busy        = active || (state_q == S_FIN);
    assign done        = done_q;
    assign err         = (state_q == S_ERR);

endmodule

// File: tb/tb_huffman_sequencer.sv
// Directed bench for huffman_sequencer with a small fixed-table decoder.
// Honours HUFF_SEQ_DC_PRED_EN for the DC predictor expectations.
module tb_huffman_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] blk_count;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [15:0] dec_code;
    logic        dec_table_sel;
    logic [3:0]  dec_run, dec_vli_size, dec_code_size;
    logic        dec_valid;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic signed [11:0] out_coef;
    logic        out_blk_end;
    logic        busy, done, err;

    always #5 clk = ~clk;

    huffman_sequencer #(.BLOCKS_W(16), .COEF_W(12)) dut (
        .clk(clk), .reset(reset), .start(start), .blk_count(blk_count),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .dec_code(dec_code), .dec_table_sel(dec_table_sel),
        .dec_run(dec_run), .dec_vli_size(dec_vli_size),
        .dec_code_size(dec_code_size), .dec_valid(dec_valid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_coef(out_coef),
        .out_blk_end(out_blk_end),
        .busy(busy), .done(done), .err(err)
    );

    // Test code tables. DC: 00=c0 010=c1 011=c2 100=c3 101=c4 110=c5
    // 1110=c6, 1111 invalid. AC: 00=EOB 01=0/1 100=2/1 101=ZRL
    // 1100=0/2 1101=14/1 1110=0/3, 1111 invalid.
    always_comb begin
        dec_valid     = 1'b1;
        dec_run       = 4'd0;
        dec_vli_size  = 4'd0;
        dec_code_size = 4'd0;
        if (!dec_table_sel) begin
            casez (dec_code[15:12])
                4'b00??: begin dec_code_size = 4'd2; end
                4'b010?: begin dec_code_size = 4'd3; dec_vli_size = 4'd1; end
                4'b011?: begin dec_code_size = 4'd3; dec_vli_size = 4'd2; end
                4'b100?: begin dec_code_size = 4'd3; dec_vli_size = 4'd3; end
                4'b101?: begin dec_code_size = 4'd3; dec_vli_size = 4'd4; end
                4'b110?: begin dec_code_size = 4'd3; dec_vli_size = 4'd5; end
                4'b1110: begin dec_code_size = 4'd4; dec_vli_size = 4'd6; end
                default: begin dec_valid = 1'b0; end
            endcase
        end else begin
            casez (dec_code[15:12])
                4'b00??: begin dec_code_size = 4'd2; end
                4'b01??: begin dec_code_size = 4'd2; dec_vli_size = 4'd1; end
                4'b100?: begin
                    dec_code_size = 4'd3; dec_run = 4'd2; dec_vli_size = 4'd1;
                end
                4'b101?: begin dec_code_size = 4'd3; dec_run = 4'd15; end
                4'b1100: begin dec_code_size = 4'd4; dec_vli_size = 4'd2; end
                4'b1101: begin
                    dec_code_size = 4'd4; dec_run = 4'd14; dec_vli_size = 4'd1;
                end
                4'b1110: begin dec_code_size = 4'd4; dec_vli_size = 4'd3; end
                default: begin dec_valid = 1'b0; end
            endcase
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // word feeder: handshake decided at negedge, queue advanced after posedge
    logic [31:0] wq[$];

    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            logic take;
            @(negedge clk);
            take = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (take && wq.size() > 0) void'(wq.pop_front());
            if (wq.size() > 0) begin
                in_valid = 1'b1;
                in_data  = wq[0];
            end else begin
                in_valid = 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset     = 1'b0;
        start     = 1'b0;
        blk_count = '0;
        out_ready = 1'b1;
        wq.delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // stream bits right-justified in sbits; pad with ones after them
    task automatic load(input logic [63:0] sbits, input int nbits);
        logic [63:0] w;
        w = (sbits << (64 - nbits)) | (~64'h0 >> nbits);
        wq.push_back(w[63:32]);
        wq.push_back(w[31:0]);
        wq.push_back(32'hFFFF_FFFF);
        wq.push_back(32'hFFFF_FFFF);
    endtask

    task automatic pulse_start(input logic [15:0] n);
        blk_count = n;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    logic [5:0]  b_idx[8];
    logic [11:0] b_coef[8];
    logic        b_end[8];
    int          nb, last_cyc, done_cyc;
    logic        busy_at_done;

    task automatic collect(input bit now);
        nb           = 0;
        last_cyc     = -1;
        done_cyc     = -1;
        busy_at_done = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c > 0 || !now) @(negedge clk);
            if (done) begin
                done_cyc     = c;
                busy_at_done = busy;
                break;
            end
            if (out_valid && out_ready) begin
                if (nb < 8) begin
                    b_idx[nb]  = out_idx;
                    b_coef[nb] = out_coef;
                    b_end[nb]  = out_blk_end;
                end
                nb++;
                last_cyc = c;
            end
            if (err) break;
        end
    endtask

    typedef struct packed {
        logic [63:0] sbits;
        logic [7:0]  nbits;
        logic [15:0] blks;
        logic [2:0]  nbeats;
        logic [23:0] idxs;
        logic [47:0] coefs;
        logic [3:0]  ends;
    } vec_t;

`ifdef HUFF_SEQ_DC_PRED_EN
    localparam logic [11:0] DC2 = 12'd7;
`else
    localparam logic [11:0] DC2 = 12'd3;
`endif

    vec_t vecs[5];

    initial begin
        // DC c2 "10" (+2), EOB
        vecs[0] = '{sbits: 64'b0111000, nbits: 8'd7, blks: 16'd1,
                    nbeats: 3'd2, idxs: 24'd0,
                    coefs: {12'd0, 12'd0, 12'd0, 12'd2}, ends: 4'b0010};
        // DC c3 "010" (-5), EOB
        vecs[1] = '{sbits: 64'b10001000, nbits: 8'd8, blks: 16'd1,
                    nbeats: 3'd2, idxs: 24'd0,
                    coefs: {12'd0, 12'd0, 12'd0, 12'hFFB}, ends: 4'b0010};
        // DC 0, 2/1 "1", ZRL, 0/1 "0", EOB
        vecs[2] = '{sbits: 64'b00100110101000, nbits: 8'd14, blks: 16'd1,
                    nbeats: 3'd4,
                    idxs: {6'd20, 6'd20, 6'd3, 6'd0},
                    coefs: {12'd0, 12'hFFF, 12'd1, 12'd0}, ends: 4'b1000};
        // two blocks, DC diffs +4, +3
        vecs[3] = '{sbits: 64'b100100000111100, nbits: 8'd15, blks: 16'd2,
                    nbeats: 3'd4, idxs: 24'd0,
                    coefs: {12'd0, DC2, 12'd0, 12'd4}, ends: 4'b1010};
        // DC 0, ZRL x3, 14/1 "1" lands on idx 63 and ends the block
        vecs[4] = '{sbits: 64'b0010110110111011, nbits: 8'd16, blks: 16'd1,
                    nbeats: 3'd2,
                    idxs: {6'd0, 6'd0, 6'd63, 6'd0},
                    coefs: {12'd0, 12'd0, 12'd1, 12'd0}, ends: 4'b0010};

        // reset values
        do_reset();
        @(negedge clk);
        chk("reset_out", {in_ready, out_valid, out_idx, out_coef, out_blk_end},
            '0);
        chk("reset_dec", {dec_code, dec_table_sel}, '0);
        chk("reset_status", {busy, done, err}, '0);

        // blk_count 0 finishes at once
        pulse_start(16'd0);
        @(negedge clk);
        chk("blk0_done", {done, busy}, 2'b10);
        @(negedge clk);
        chk("blk0_pulse", {done, busy}, 2'b00);

        for (int k = 0; k < 5; k++) begin
            do_reset();
            load(vecs[k].sbits, int'(vecs[k].nbits));
            pulse_start(vecs[k].blks);
            collect(1'b0);
            chk($sformatf("v%0d_nbeats", k), 64'(nb),
                64'(vecs[k].nbeats));
            for (int i = 0; i < int'(vecs[k].nbeats); i++) begin
                chk($sformatf("v%0d_beat%0d", k, i),
                    {b_idx[i], b_coef[i], b_end[i]},
                    {vecs[k].idxs[6*i +: 6], vecs[k].coefs[12*i +: 12],
                     vecs[k].ends[i]});
            end
            chk($sformatf("v%0d_done_gap", k), 64'(done_cyc),
                64'(last_cyc + 1));
            chk($sformatf("v%0d_busy_done", k), 64'(busy_at_done), 64'd0);
        end

        // backpressure: beat and buffer frozen while out_ready is low
        do_reset();
        out_ready = 1'b0;
        load(64'b10001000, 8);
        pulse_start(16'd1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold_%0d", i),
                {out_valid, out_idx, out_coef, out_blk_end, dec_code,
                 dec_table_sel, in_ready},
                {1'b1, 6'd0, 12'hFFB, 1'b0, 16'h3FFF, 1'b1, 1'b0});
            @(negedge clk);
        end
        out_ready = 1'b1;
        collect(1'b1);
        chk("hold_nbeats", 64'(nb), 64'd2);
        chk("hold_beat0", {b_idx[0], b_coef[0], b_end[0]},
            {6'd0, 12'hFFB, 1'b0});
        chk("hold_beat1", {b_idx[1], b_coef[1], b_end[1]},
            {6'd0, 12'd0, 1'b1});
        chk("hold_done_gap", 64'(done_cyc), 64'(last_cyc + 1));

        // invalid DC code
        do_reset();
        load(64'd0, 0);
        pulse_start(16'd1);
        repeat (6) @(negedge clk);
        chk("inv_err", {err, in_ready, out_valid, busy}, 4'b1000);
        @(posedge clk);
        #1;
        pulse_start(16'd1);
        repeat (4) @(negedge clk);
        chk("inv_sticky", {err, in_ready, out_valid}, 3'b100);
        reset = 1'b0;
        #1;
        chk("inv_async_clr", {err, busy, out_valid}, 3'b000);
        reset = 1'b1;

        // index overflow: ZRL x3, 2/1 -> 51, then 14/1 would reach 66
        do_reset();
        load(64'b00101101101100111011, 20);
        pulse_start(16'd1);
        collect(1'b0);
        chk("ovf_nbeats", 64'(nb), 64'd2);
        chk("ovf_beat1", {b_idx[1], b_coef[1], b_end[1]},
            {6'd51, 12'd1, 1'b0});
        @(negedge clk);
        chk("ovf_err", {err, in_ready, out_valid, done}, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
